// File: rtl/keypad_pkg.sv
// Shared types for the keypad code-entry block: debounce FSM states and the
// 4-bit digit type carried from the keypad decoder.
package keypad_pkg;

  typedef logic [3:0] digit_t;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

endpackage

// File: rtl/keypad_debounce.sv
// Synchronizes the asynchronous decoder outputs and debounces them. Emits one
// key strobe per physical press, with the accepted digit held on o_key_code.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
)(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   i_valid,
  input  digit_t i_number,
  output logic   o_key_strobe,
  output digit_t o_key_code
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

  logic             r_valid_meta;
  logic             r_valid_sync;
  digit_t           r_number_meta;
  digit_t           r_number_sync;

  key_state_e       r_state;
  key_state_e       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_cnt_inc;
  digit_t           r_cand;
  digit_t           w_cand_next;
  logic             w_strobe_set;
  logic             r_key_strobe;
  digit_t           r_key_code;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Two-flop synchronizer; nothing downstream looks at the raw decoder pins.
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
  // pre-edge value of its source; blocking here would collapse the two stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid_meta  <= 1'b0;
      r_valid_sync  <= 1'b0;
      r_number_meta <= '0;
      r_number_sync <= '0;
    end else begin
      r_valid_meta  <= i_valid;
      r_valid_sync  <= r_valid_meta;
      r_number_meta <= i_number;
      r_number_sync <= r_number_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic, including the stability counter and candidate digit.
  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_cand_next  = r_cand;
    unique case (r_state)
      IDLE: begin
        if (r_valid_sync) begin
          w_cand_next  = r_number_sync;
          w_cnt_next   = CNT_ONE;
          w_state_next = (CNT_ONE == CNT_DONE) ? HELD : PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (!r_valid_sync) begin
          w_state_next = IDLE;
        end else if (r_number_sync != r_cand) begin
          // A different digit restarts the stability count on the new value.
          w_cand_next  = r_number_sync;
          w_cnt_next   = CNT_ONE;
          w_state_next = (CNT_ONE == CNT_DONE) ? HELD : PRESS_WAIT;
        end else begin
          w_cnt_next = w_cnt_inc;
          if (w_cnt_inc == CNT_DONE) w_state_next = HELD;
        end
      end
      HELD: begin
        // Digit changes while held are ignored; only release matters here.
        if (!r_valid_sync) begin
          w_cnt_next   = CNT_ONE;
          w_state_next = (CNT_ONE == CNT_DONE) ? IDLE : RELEASE_WAIT;
        end
      end
      RELEASE_WAIT: begin
        if (r_valid_sync) begin
          w_state_next = HELD;
        end else begin
          w_cnt_next = w_cnt_inc;
          if (w_cnt_inc == CNT_DONE) w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Output decode: a press is accepted on the transition into HELD from the
  // press side only, so a bounce during release never strobes again.
  always_comb begin
    w_strobe_set = 1'b0;
    if ((r_state == IDLE || r_state == PRESS_WAIT) && w_state_next == HELD)
      w_strobe_set = 1'b1;
  end

  // Counter, candidate and registered strobe / key code.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt        <= '0;
      r_cand       <= '0;
      r_key_strobe <= 1'b0;
      r_key_code   <= '0;
    end else begin
      r_cnt        <= w_cnt_next;
      r_cand       <= w_cand_next;
      r_key_strobe <= w_strobe_set;
      if (w_strobe_set) r_key_code <= w_cand_next;
    end
  end

  assign o_key_strobe = r_key_strobe;
  assign o_key_code   = r_key_code;

endmodule

// File: rtl/keypad_code_entry.sv
// Keypad code entry: debounced key strobes are accumulated into a BCD entry
// buffer, compared against PIN on the final digit, with a fail counter that
// latches a lockout until reset.
module keypad_code_entry
  import keypad_pkg::*;
#(
  parameter int                      DEBOUNCE_CYCLES = 4,
  parameter int                      CODE_LEN        = 4,
  parameter logic [4*CODE_LEN-1:0]   PIN             = 16'h1234,
  parameter int                      MAX_FAIL        = 3
)(
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          valid,
  input  digit_t                        number,
  input  logic                          clear,
  output logic                          key_strobe,
  output digit_t                        key_code,
  output logic [$clog2(CODE_LEN+1)-1:0] digit_count,
  output logic                          code_match,
  output logic                          code_fail,
  output logic                          locked
);

  localparam int BUF_W  = 4 * CODE_LEN;
  localparam int CNT_W  = $clog2(CODE_LEN + 1);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  logic              w_key_strobe;
  digit_t            w_key_code;

  logic [BUF_W-1:0]  r_buf;
  logic [BUF_W+3:0]  w_buf_ext;
  logic [BUF_W-1:0]  w_buf_shift;
  logic [CNT_W-1:0]  r_count;
  logic              w_final;
  logic              w_accept;
  logic              w_equal;
  logic              r_match;
  logic              r_fail;
  logic [FAIL_W-1:0] r_fail_cnt;
  logic [FAIL_W-1:0] w_fail_inc;
  logic              r_locked;

  keypad_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_valid      (valid),
    .i_number     (number),
    .o_key_strobe (w_key_strobe),
    .o_key_code   (w_key_code)
  );

  // Oldest digit ends up in the MS nibble once CODE_LEN digits are shifted in.
  assign w_buf_ext   = {r_buf, w_key_code};
  assign w_buf_shift = w_buf_ext[BUF_W-1:0];

  // The compare cycle is the one in which the buffer holds a full entry.
  assign w_final    = (r_count == CNT_W'(CODE_LEN));
  assign w_equal    = (r_buf == PIN);
  assign w_accept   = w_key_strobe && !r_locked && !clear && !w_final;
  assign w_fail_inc = r_fail_cnt + FAIL_W'(1);

  // Entry buffer and digit count: compare and clear both empty the buffer;
  // a clear coincident with a strobe discards that digit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf   <= '0;
      r_count <= '0;
    end else if (w_final || clear) begin
      r_buf   <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_buf   <= w_buf_shift;
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Compare pulses, consecutive-fail counter and the sticky lockout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_match    <= 1'b0;
      r_fail     <= 1'b0;
      r_fail_cnt <= '0;
      r_locked   <= 1'b0;
    end else begin
      r_match <= w_final && w_equal;
      r_fail  <= w_final && !w_equal;
      if (w_final) begin
        if (w_equal) begin
          r_fail_cnt <= '0;
        end else begin
          r_fail_cnt <= w_fail_inc;
          if (w_fail_inc == FAIL_W'(MAX_FAIL)) r_locked <= 1'b1;
        end
      end
    end
  end

  assign key_strobe  = w_key_strobe;
  assign key_code    = w_key_code;
  assign digit_count = r_count;
  assign code_match  = r_match;
  assign code_fail   = r_fail;
  assign locked      = r_locked;

endmodule

// File: tb/tb_keypad_code_entry.sv
// Self-checking bench for keypad_code_entry: a scoreboard of expected strobes
// and compare results is filled as presses are driven and drained by a monitor.
module tb_keypad_code_entry;
  import keypad_pkg::*;

  localparam int          DEB      = 4;
  localparam int          CODE_LEN = 4;
  localparam logic [15:0] PIN      = 16'h1234;
  localparam int          MAX_FAIL = 3;
  localparam int          CW       = $clog2(CODE_LEN + 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          valid = 1'b0;
  digit_t        number = '0;
  logic          clear = 1'b0;
  logic          key_strobe;
  digit_t        key_code;
  logic [CW-1:0] digit_count;
  logic          code_match;
  logic          code_fail;
  logic          locked;

  keypad_code_entry #(
    .DEBOUNCE_CYCLES (DEB),
    .CODE_LEN        (CODE_LEN),
    .PIN             (PIN),
    .MAX_FAIL        (MAX_FAIL)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .valid       (valid),
    .number      (number),
    .clear       (clear),
    .key_strobe  (key_strobe),
    .key_code    (key_code),
    .digit_count (digit_count),
    .code_match  (code_match),
    .code_fail   (code_fail),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard queues and reference model state.
  typedef struct {
    bit match;
    bit lock;
  } result_t;

  digit_t  strobe_q[$];
  result_t result_q[$];
  digit_t  m_buf[$];
  int      m_fails = 0;
  bit      m_locked = 1'b0;
  bit      exp_locked = 1'b0;
  int      last_strobe_cyc = -1;
  digit_t  mon_d;
  result_t mon_r;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (key_strobe) begin
        last_strobe_cyc = cyc;
        if (strobe_q.size() == 0) begin
          check("extra_strobe", 32'd1, 32'd0);
        end else begin
          mon_d = strobe_q.pop_front();
          check("strobe_key_code", 32'(key_code), 32'(mon_d));
        end
      end
      if (code_match || code_fail) begin
        if (result_q.size() == 0) begin
          check("extra_result", 32'd1, 32'd0);
        end else begin
          mon_r = result_q.pop_front();
          check("code_match", 32'(code_match), 32'(mon_r.match));
          check("code_fail", 32'(code_fail), 32'(!mon_r.match));
          exp_locked = mon_r.lock;
        end
      end
      check("locked_level", 32'(locked), 32'(exp_locked));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference model for one accepted digit; returns the digit count expected
  // in the cycle right after the strobe is consumed.
  task automatic model_digit(input digit_t d, input bit clr, output int exp_cnt);
    logic [15:0] v;
    bit          eq;
    if (m_locked) begin
      exp_cnt = m_buf.size();
    end else if (clr) begin
      m_buf.delete();
      exp_cnt = 0;
    end else begin
      m_buf.push_back(d);
      exp_cnt = m_buf.size();
      if (m_buf.size() == CODE_LEN) begin
        v = '0;
        foreach (m_buf[i]) v = {v[11:0], m_buf[i]};
        eq = (v == PIN);
        if (eq) m_fails = 0;
        else    m_fails++;
        if (m_fails >= MAX_FAIL) m_locked = 1'b1;
        result_q.push_back('{match: eq, lock: m_locked});
        m_buf.delete();
      end
    end
  endtask

  // One clean press: held for 'hold' cycles, optional clear on the strobe cycle.
  task automatic press(input digit_t d, input int hold = 13, input bit clr = 1'b0);
    int c;
    int exp_cnt;
    valid  = 1'b1;
    number = d;
    c      = cyc;
    strobe_q.push_back(d);
    model_digit(d, clr, exp_cnt);
    repeat (6) step();
    if (clr) clear = 1'b1;
    step();
    clear = 1'b0;
    check("strobe_latency", 32'(last_strobe_cyc - c), 32'(DEB + 2));
    check("digit_count", 32'(digit_count), 32'(exp_cnt));
    check("key_code_hold", 32'(key_code), 32'(d));
    repeat (hold - 7) step();
    valid = 1'b0;
    repeat (DEB + 6) step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strobe"}, 32'(key_strobe), 32'd0);
    check({tag, "_key_code"}, 32'(key_code), 32'd0);
    check({tag, "_digit_count"}, 32'(digit_count), 32'd0);
    check({tag, "_match"}, 32'(code_match), 32'd0);
    check({tag, "_fail"}, 32'(code_fail), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
  endtask

  task automatic model_reset();
    m_buf.delete();
    m_fails    = 0;
    m_locked   = 1'b0;
    exp_locked = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    int r;

    // Reset state.
    #1 reset_n = 1'b0;
    #1 check_all_zero("reset");
    step();
    step();
    reset_n = 1'b1;
    step();

    // Single long press: exactly one strobe at E1+DEB latency.
    press(4'd5, 20);

    // Bouncy press of 7, then bouncy release.
    number = 4'd7;
    for (int i = 0; i < 4; i++) begin
      valid = (i % 2 == 0);
      step();
    end
    valid = 1'b1;
    c     = cyc;
    strobe_q.push_back(4'd7);
    begin
      int ec;
      model_digit(4'd7, 1'b0, ec);
      repeat (7) step();
      check("bounce_latency", 32'(last_strobe_cyc - c), 32'(DEB + 2));
      check("bounce_count", 32'(digit_count), 32'(ec));
    end
    repeat (5) step();
    for (int i = 0; i < 4; i++) begin
      valid = (i % 2 == 1);
      step();
    end
    valid = 1'b0;
    repeat (DEB + 6) step();

    // Standalone clear of the partial entry.
    clear = 1'b1;
    step();
    clear = 1'b0;
    m_buf.delete();
    step();
    check("clear_count", 32'(digit_count), 32'd0);

    // One wrong entry, then the correct one (match must reset the fail count).
    for (int i = 0; i < 4; i++) press(4'd9);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    check("after_match_count", 32'(digit_count), 32'd0);

    // Three wrong entries lock; a correct entry while locked is ignored.
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++) press(4'd9);
    check("locked_set", 32'(locked), 32'd1);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    check("locked_count", 32'(digit_count), 32'd0);
    reset_n = 1'b0;
    #1 check("reset_unlocks", 32'(locked), 32'd0);
    model_reset();
    step();
    reset_n = 1'b1;
    step();

    // Clear coincident with the third digit's strobe discards it.
    press(4'd1);
    press(4'd2);
    press(4'd3, 13, 1'b1);
    check("clear_strobe_count", 32'(digit_count), 32'd0);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);

    // Reset during PRESS_WAIT with the key held, then full re-debounce.
    press(4'd5);
    valid  = 1'b1;
    number = 4'd8;
    repeat (3) step();
    reset_n = 1'b0;
    #1 check_all_zero("midpress_reset");
    model_reset();
    step();
    step();
    reset_n = 1'b1;
    r = cyc;
    strobe_q.push_back(4'd8);
    begin
      int ec;
      model_digit(4'd8, 1'b0, ec);
      repeat (7) step();
      check("reset_held_latency", 32'(last_strobe_cyc - r), 32'(DEB + 2));
      check("reset_held_count", 32'(digit_count), 32'(ec));
      check("reset_held_code", 32'(key_code), 32'd8);
    end
    repeat (6) step();
    valid = 1'b0;
    repeat (DEB + 6) step();

    check("strobe_q_empty", 32'(strobe_q.size()), 32'd0);
    check("result_q_empty", 32'(result_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_code_entry.md
Name: keypad_code_entry

Overview:
Downstream consumer of the combinational keypad decoder (valid, number[3:0], digits 0-9). Synchronizes and debounces the decoded key, emits exactly one strobe per physical press, and accumulates digits into a CODE_LEN-digit BCD entry buffer. On entry of the final digit it compares the buffer against a PIN and pulses match or fail. It latches a lockout after MAX_FAIL consecutive failures.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a press or a release (>=1)
CODE_LEN, 4, digits per code entry (1..8)
PIN, 16'h1234, expected code, BCD, 4 bits per digit, first-entered digit in MS nibble; width 4*CODE_LEN
MAX_FAIL, 3, consecutive failed entries that trigger lockout (>=1)

Ports:
clk  input  1  single clock, rising edge
reset_n  input  1  asynchronous, active-low reset
valid  input  1  decoder valid, asynchronous to clk
number  input  4  decoder digit 0-9, meaningful only when valid=1
clear  input  1  synchronous; discards partial entry
key_strobe  output  1  one-cycle pulse per accepted press
key_code  output  4  digit of the last accepted press; holds between strobes
digit_count  output  $clog2(CODE_LEN+1)  digits currently buffered
code_match  output  1  one-cycle pulse: entry equals PIN
code_fail  output  1  one-cycle pulse: entry differs from PIN
locked  output  1  level; lockout active

Behaviour:
- Reset (async, reset_n=0): all outputs 0; sync flops 0; FSM IDLE; debounce counter, fail counter and buffer 0.
- Synchronizer: 2-flop stage on valid and number. s_valid and s_number are the second-stage outputs. No logic uses the raw inputs.
- FSM states:
  IDLE: s_valid=1 -> PRESS_WAIT; capture cand=s_number; cnt=1.
  PRESS_WAIT: s_valid=0 -> IDLE. s_number!=cand -> stay; cand=s_number; cnt=1. Otherwise cnt++.
  cnt reaching DEBOUNCE_CYCLES -> HELD; key_strobe=1 next cycle; key_code=cand.
  HELD: s_valid=0 -> RELEASE_WAIT; cnt=1. A number change while held is ignored (no second strobe).
  RELEASE_WAIT: s_valid=1 -> HELD. Otherwise cnt++; at DEBOUNCE_CYCLES -> IDLE.
- Timing: raw inputs stable from sampling edge E0 give key_strobe high for the single cycle following edge E1+DEBOUNCE_CYCLES. With the default of 4, that is the cycle after E5.
- Accumulator, on key_strobe with locked=0:
  - buffer = {buffer[4*CODE_LEN-5:0], key_code}; digit_count++.
  - When this is the CODE_LEN-th digit, the next cycle pulses code_match (buffer==PIN) or code_fail. The same edge returns digit_count and buffer to 0.
- Fail counter:
  - code_match resets it to 0.
  - code_fail increments it; reaching MAX_FAIL sets locked=1 in the same cycle as the code_fail pulse.
- locked=1: key_strobe and key_code still operate; digits are not buffered; no match/fail pulses. Only reset_n clears locked.
- clear=1: buffer and digit_count go to 0 next edge; fail counter is unchanged.
  - clear coincident with a strobe: clear wins and the digit is discarded.
  - clear coincident with the final-digit compare cycle: the compare pulse still issues.
- Reset mid-press: FSM returns to IDLE. A key still held after release of reset must pass the full debounce again before it strobes.
- Digit values 10-15 are never produced by the decoder. If present, they are buffered as-is (no special case).

Decomposition:
- Shared package keypad_pkg holds the FSM state enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT) and the digit typedef (logic [3:0]).
- One natural sub-module, keypad_debounce: synchronizer plus FSM, producing key_strobe and key_code.
- The top level holds the accumulator, comparator, fail counter and lockout.

Test Plan:
1. Default params; number=5, valid=1 held 20 cycles from E0 -> exactly one key_strobe, in the cycle after E5, key_code=5; no further strobes while held.
2. Bounce: valid toggles 1,0,1,0 per cycle, then stable high with number=7 -> one strobe only, DEBOUNCE_CYCLES after the stable period begins; release bounce produces no extra strobe.
3. Presses 1,2,3,4 (each with clean release) -> digit_count 1,2,3,4 then 0; code_match pulses once; code_fail stays 0; fail counter 0.
4. Three entries of 9,9,9,9 -> three code_fail pulses; locked=1 with the third. A fifth correct entry 1,2,3,4 gives strobes but no match and digit_count stays 0. reset_n low clears locked.
5. Press 1,2, then clear on the same cycle as the third digit's strobe -> digit_count=0; then 1,2,3,4 -> code_match.
6. reset_n asserted during PRESS_WAIT with key held -> all outputs 0 immediately. After release of reset, the held key strobes after the full E1+DEBOUNCE_CYCLES latency.
